// File: rtl/div_unit_if.sv
// Handshake bundle between the execute stage and the iterative divider.
// The execute stage is the master; div_unit is the slave.
interface div_unit_if;
  logic        start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        div_stall;

  modport master (
    output start, signed_div, opdata1, opdata2, annul,
    input  result, ready, div_stall
  );

  modport slave (
    input  start, signed_div, opdata1, opdata2, annul,
    output result, ready, div_stall
  );
endinterface

// File: rtl/div_unit.sv
// Iterative 32-bit DIV/DIVU unit: one restoring shift-subtract step per cycle,
// result packed as {remainder (HI), quotient (LO)}.
module div_unit (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BYZERO = 2'd1;
  localparam logic [1:0] S_ON     = 2'd2;
  localparam logic [1:0] S_END    = 2'd3;

  logic [1:0]  state;
  logic [5:0]  count;
  logic [64:0] work;      // {partial remainder[32:0], dividend/quotient[31:0]}
  logic [31:0] divisor;
  logic        neg_q;
  logic        neg_r;
  logic [63:0] result_q;
  logic        ready_q;

  logic [31:0] mag1;
  logic [31:0] mag2;
  logic [64:0] shifted;
  logic [32:0] diff;
  logic [64:0] work_next;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  // Operand magnitudes; in signed mode the most negative value maps onto
  // itself, which is the correct unsigned magnitude 2^31.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    mag1 = bus.opdata1;
    mag2 = bus.opdata2;
    if (bus.signed_div) begin
      if (bus.opdata1[31]) mag1 = ~bus.opdata1 + 32'd1;
      if (bus.opdata2[31]) mag2 = ~bus.opdata2 + 32'd1;
    end
  end

  // Partial remainder is always below the divisor, so after the shift it
  // fits in 33 bits and diff[32] is a reliable borrow flag.
  always_comb begin
    shifted   = work << 1;
    diff      = shifted[64:32] - {1'b0, divisor};
    work_next = shifted;
    if (!diff[32]) work_next = {diff, shifted[31:1], 1'b1};
  end

  always_comb begin
    quot_fix = neg_q ? (~work[31:0]  + 32'd1) : work[31:0];
    rem_fix  = neg_r ? (~work[63:32] + 32'd1) : work[63:32];
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values and the step order inside the block is moot.
    if (rst) begin
      state    <= S_IDLE;
      count    <= 6'd0;
      work     <= 65'd0;
      divisor  <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_q <= 64'd0;
      ready_q  <= 1'b0;
    end else if (bus.annul) begin
      state   <= S_IDLE;
      count   <= 6'd0;
      work    <= 65'd0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ready_q <= 1'b0;
          if (bus.start) begin
            state   <= (bus.opdata2 == 32'd0) ? S_BYZERO : S_ON;
            count   <= 6'd0;
            work    <= {33'd0, mag1};
            divisor <= mag2;
            neg_q   <= bus.signed_div & (bus.opdata1[31] ^ bus.opdata2[31]);
            neg_r   <= bus.signed_div & bus.opdata1[31];
          end
        end
        S_BYZERO: begin
          work  <= 65'd0;
          neg_q <= 1'b0;
          neg_r <= 1'b0;
          state <= S_END;
        end
        S_ON: begin
          work  <= work_next;
          count <= count + 6'd1;
          if (count == 6'd31) state <= S_END;
        end
        default: begin
          // Exit on the first cycle start is low, even before ready rose.
          if (!bus.start) begin
            state   <= S_IDLE;
            ready_q <= 1'b0;
          end else begin
            ready_q  <= 1'b1;
            result_q <= {rem_fix, quot_fix};
          end
        end
      endcase
    end
  end

  assign bus.result    = result_q;
  assign bus.ready     = ready_q;
  assign bus.div_stall = bus.start & ~ready_q & ~bus.annul;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of expected results, one task
// per scenario, latency and stall behaviour checked alongside the results.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst;

  div_unit_if bus();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [63:0] sb[$];

  function automatic logic [63:0] ref_div(input logic sd, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return 64'd0;
    if (!sd) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {r, q};
  endfunction

  task tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic sd, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    bus.start      = 1'b1;
    bus.signed_div = sd;
    bus.opdata1    = a;
    bus.opdata2    = b;
    sb.push_back(exp);
  endtask

  // Advance edges until ready; e is the index of the edge after which ready
  // was seen (edge 0 samples start), or -1 if the budget expired.
  task automatic wait_ready(input int e0, output int e, output bit stall_ok);
    e = e0;
    stall_ok = 1'b1;
    for (int k = 0; k < 60; k++) begin
      #1;
      if (bus.div_stall !== 1'b1) stall_ok = 1'b0;
      tick;
      e++;
      if (bus.ready === 1'b1) return;
    end
    e = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b0; bus.signed_div = 1'b0; bus.annul = 1'b0;
    bus.opdata1 = 32'd0; bus.opdata2 = 32'd0;
    tick; tick;
    tests_run++; if (bus.ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready got=%b exp=0", bus.ready); end
    tests_run++; if (bus.result !== 64'd0) begin tests_failed++; $display("FAIL reset_result got=%h exp=0", bus.result); end
    tests_run++; if (bus.div_stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall_idle got=%b exp=0", bus.div_stall); end
    bus.start = 1'b1;
    #1;
    tests_run++; if (bus.div_stall !== 1'b1) begin tests_failed++; $display("FAIL reset_stall_start got=%b exp=1", bus.div_stall); end
    bus.start = 1'b0;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_divu_basic;
    int e; bit s; logic [63:0] exp;
    issue(1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
    wait_ready(-1, e, s);
    exp = sb.pop_front();
    tests_run++; if (e !== 33) begin tests_failed++; $display("FAIL divu_latency got=%0d exp=33", e); end
    tests_run++; if (!s) begin tests_failed++; $display("FAIL divu_stall_busy got=0 exp=1"); end
    tests_run++; if (bus.div_stall !== 1'b0) begin tests_failed++; $display("FAIL divu_stall_done got=%b exp=0", bus.div_stall); end
    tests_run++; if (bus.result !== exp) begin tests_failed++; $display("FAIL divu_result got=%h exp=%h", bus.result, exp); end
    tick;
    tests_run++; if (bus.ready !== 1'b1 || bus.result !== exp) begin tests_failed++; $display("FAIL divu_hold got=%b/%h exp=1/%h", bus.ready, bus.result, exp); end
    bus.start = 1'b0;
    tick;
    tests_run++; if (bus.ready !== 1'b0) begin tests_failed++; $display("FAIL divu_exit_ready got=%b exp=0", bus.ready); end
    tests_run++; if (bus.result !== exp) begin tests_failed++; $display("FAIL divu_result_held got=%h exp=%h", bus.result, exp); end
  endtask

  task automatic test_signed;
    int e; bit s; logic [63:0] exp;
    logic [31:0] a_v[2];
    logic [31:0] b_v[2];
    logic [63:0] x_v[2];
    a_v[0] = 32'hFFFF_FFF9; b_v[0] = 32'd2;          x_v[0] = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
    a_v[1] = 32'd7;         b_v[1] = 32'hFFFF_FFFE;  x_v[1] = {32'h0000_0001, 32'hFFFF_FFFD};
    for (int i = 0; i < 2; i++) begin
      issue(1'b1, a_v[i], b_v[i], x_v[i]);
      wait_ready(-1, e, s);
      exp = sb.pop_front();
      tests_run++; if (bus.result !== exp) begin tests_failed++; $display("FAIL signed_vec%0d got=%h exp=%h", i, bus.result, exp); end
      bus.start = 1'b0;
      tick;
    end
  endtask

  task automatic test_random;
    int e; bit s; logic [63:0] exp; logic sd; logic [31:0] a; logic [31:0] b;
    for (int i = 0; i < 8; i++) begin
      sd = 1'(i % 2);
      a  = $urandom;
      b  = $urandom;
      if (i >= 4) b = b >> $urandom_range(16, 31);
      issue(sd, a, b, ref_div(sd, a, b));
      wait_ready(-1, e, s);
      exp = sb.pop_front();
      tests_run++; if (e !== ((b == 32'd0) ? 2 : 33)) begin tests_failed++; $display("FAIL rand%0d_latency got=%0d", i, e); end
      tests_run++; if (bus.result !== exp) begin tests_failed++; $display("FAIL rand%0d_result sd=%b a=%h b=%h got=%h exp=%h", i, sd, a, b, bus.result, exp); end
      bus.start = 1'b0;
      tick;
    end
  endtask

  task automatic test_byzero;
    int e; bit s; logic [63:0] exp;
    issue(1'b0, 32'd5, 32'd0, 64'd0);
    wait_ready(-1, e, s);
    exp = sb.pop_front();
    tests_run++; if (e !== 2) begin tests_failed++; $display("FAIL byzero_latency got=%0d exp=2", e); end
    tests_run++; if (bus.result !== exp) begin tests_failed++; $display("FAIL byzero_result got=%h exp=%h", bus.result, exp); end
    bus.start = 1'b0;
    tick;
    tests_run++; if (bus.ready !== 1'b0) begin tests_failed++; $display("FAIL byzero_exit got=%b exp=0", bus.ready); end
  endtask

  task automatic test_annul;
    int e; bit s; logic [63:0] exp;
    issue(1'b0, 32'hFFFF_FFFF, 32'd3, ref_div(1'b0, 32'hFFFF_FFFF, 32'd3));
    tick;
    for (int i = 0; i < 10; i++) tick;
    bus.annul = 1'b1;
    #1;
    tests_run++; if (bus.div_stall !== 1'b0) begin tests_failed++; $display("FAIL annul_stall got=%b exp=0", bus.div_stall); end
    tick;
    tests_run++; if (bus.ready !== 1'b0) begin tests_failed++; $display("FAIL annul_ready got=%b exp=0", bus.ready); end
    void'(sb.pop_front());
    bus.annul = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < 40; i++) tick;
    tests_run++; if (bus.ready !== 1'b0) begin tests_failed++; $display("FAIL annul_no_completion got=%b exp=0", bus.ready); end
    issue(1'b0, 32'd9, 32'd3, {32'd0, 32'd3});
    wait_ready(-1, e, s);
    exp = sb.pop_front();
    tests_run++; if (e !== 33) begin tests_failed++; $display("FAIL annul_next_latency got=%0d exp=33", e); end
    tests_run++; if (bus.result !== exp) begin tests_failed++; $display("FAIL annul_next_result got=%h exp=%h", bus.result, exp); end
    bus.start = 1'b0;
    tick;
  endtask

  task automatic test_overflow_operand_change;
    int e; bit s; logic [63:0] exp;
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
    tick;
    for (int i = 0; i < 4; i++) tick;
    bus.opdata1    = $urandom;
    bus.opdata2    = 32'd0;
    bus.signed_div = 1'b0;
    wait_ready(4, e, s);
    exp = sb.pop_front();
    tests_run++; if (e !== 33) begin tests_failed++; $display("FAIL ovf_latency got=%0d exp=33", e); end
    tests_run++; if (bus.result !== exp) begin tests_failed++; $display("FAIL ovf_result got=%h exp=%h", bus.result, exp); end
    bus.start = 1'b0;
    tick;
  endtask

  task automatic test_start_drop;
    int e; bit s; logic [63:0] exp;
    issue(1'b1, 32'hFFFF_FF9C, 32'd7, ref_div(1'b1, 32'hFFFF_FF9C, 32'd7));
    tick;
    for (int i = 0; i < 5; i++) tick;
    bus.start   = 1'b0;
    bus.opdata1 = 32'd1;
    bus.opdata2 = 32'd1;
    for (int i = 0; i < 3; i++) tick;
    bus.start = 1'b1;
    wait_ready(8, e, s);
    exp = sb.pop_front();
    tests_run++; if (e !== 33) begin tests_failed++; $display("FAIL drop_latency got=%0d exp=33", e); end
    tests_run++; if (bus.result !== exp) begin tests_failed++; $display("FAIL drop_result got=%h exp=%h", bus.result, exp); end
    bus.start = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid;
    int e; bit s; logic [63:0] exp;
    issue(1'b0, 32'hFFFF_FFFF, 32'd3, ref_div(1'b0, 32'hFFFF_FFFF, 32'd3));
    tick;
    for (int i = 0; i < 20; i++) tick;
    rst = 1'b1;
    tick;
    tests_run++; if (bus.ready !== 1'b0) begin tests_failed++; $display("FAIL rstmid_ready got=%b exp=0", bus.ready); end
    tests_run++; if (bus.result !== 64'd0) begin tests_failed++; $display("FAIL rstmid_result got=%h exp=0", bus.result); end
    void'(sb.pop_front());
    issue(1'b0, 32'd50, 32'd5, {32'd0, 32'd10});
    rst = 1'b0;
    wait_ready(-1, e, s);
    exp = sb.pop_front();
    tests_run++; if (e !== 33) begin tests_failed++; $display("FAIL rstmid_fresh_latency got=%0d exp=33", e); end
    tests_run++; if (bus.result !== exp) begin tests_failed++; $display("FAIL rstmid_fresh_result got=%h exp=%h", bus.result, exp); end
    bus.start = 1'b0;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_divu_basic;
    test_signed;
    test_random;
    test_byzero;
    test_annul;
    test_overflow_operand_change;
    test_start_drop;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
